// File: rtl/led_source_sched.sv
// led_source_sched: picks which pattern source drives the 16 front-panel LEDs.
// Fixed priority ERR > OVR > NOLINK > CYLON > LOGIC, minimum dwell per source,
// blanking on every non-error switch, and the slow-control override handshake.
`timescale 1ns/1ps

module led_source_sched #(
  parameter int unsigned DWELL_CYCLES = 4000000,
  parameter int unsigned BLANK_CYCLES = 400000,
  parameter int unsigned CNT_WIDTH    = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        err_req,
  input  logic [15:0] err_led,
  input  logic        nolink_req,
  input  logic        fader_led,
  input  logic        cylon_req,
  input  logic [15:0] cylon_led,
  input  logic [15:0] logic_led,
  input  logic        ovr_req,
  input  logic [15:0] ovr_pattern,
  input  logic [23:0] ovr_cycles,
  output logic        ovr_busy,
  output logic        ovr_done,
  output logic        ovr_aborted,
  output logic [15:0] led_out,
  output logic [2:0]  src_sel,
  output logic [15:0] switch_count
);

  localparam logic [2:0] SRC_LOGIC  = 3'd0;
  localparam logic [2:0] SRC_CYLON  = 3'd1;
  localparam logic [2:0] SRC_NOLINK = 3'd2;
  localparam logic [2:0] SRC_OVR    = 3'd3;
  localparam logic [2:0] SRC_ERR    = 3'd4;

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  localparam logic [CNT_WIDTH-1:0] DWELL_MAX  = CNT_WIDTH'(DWELL_CYCLES);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST =
    (BLANK_CYCLES == 0) ? '0 : CNT_WIDTH'(BLANK_CYCLES - 1);
  localparam logic BLANK_EN = (BLANK_CYCLES != 0);

  logic [0:0]           state, state_n;
  logic [2:0]           cur, cur_n;
  logic [CNT_WIDTH-1:0] dwell_cnt, dwell_n;
  logic [CNT_WIDTH-1:0] blank_cnt, blank_n;
  logic [15:0]          led_n;
  logic [15:0]          switch_n;

  logic                 ovr_req_q;
  logic [23:0]          ovr_cnt, ovr_cnt_n;
  logic [15:0]          ovr_pat, ovr_pat_n;
  logic                 busy_n, done_n, abort_n;

  logic                 ovr_show_c, ovr_ending_c, ovr_live_c;
  logic [2:0]           want_c;

  assign src_sel = cur;

  // Wanted source; an override on its last displayed cycle no longer counts as active
  always_comb begin
    ovr_show_c   = ovr_busy && (state == ST_SHOW) && (cur == SRC_OVR);
    ovr_ending_c = ovr_show_c && (ovr_cnt == 24'd1);
    ovr_live_c   = ovr_busy && !ovr_ending_c;
    if (err_req)         want_c = SRC_ERR;
    else if (ovr_live_c) want_c = SRC_OVR;
    else if (nolink_req) want_c = SRC_NOLINK;
    else if (cylon_req)  want_c = SRC_CYLON;
    else                 want_c = SRC_LOGIC;
  end

  // Scheduler next state: dwell gating, blanking, immediate preemption by ERR
  always_comb begin
    state_n = state;
    cur_n   = cur;
    blank_n = blank_cnt;
    dwell_n = (dwell_cnt >= DWELL_MAX) ? dwell_cnt : dwell_cnt + CNT_WIDTH'(1);
    if (state == ST_SHOW) begin
      if ((want_c != cur) &&
          ((want_c == SRC_ERR) || (dwell_cnt >= DWELL_MAX) ||
           ((cur == SRC_OVR) && !ovr_live_c))) begin
        cur_n = want_c;
        if ((want_c == SRC_ERR) || !BLANK_EN) begin
          dwell_n = '0;
        end else begin
          state_n = ST_BLANK;
          blank_n = '0;
        end
      end
    end else begin
      dwell_n = '0;
      if (want_c == SRC_ERR) begin
        cur_n   = SRC_ERR;
        state_n = ST_SHOW;
      end else if (blank_cnt >= BLANK_LAST) begin
        cur_n   = want_c;
        state_n = ST_SHOW;
      end else begin
        blank_n = blank_cnt + CNT_WIDTH'(1);
      end
    end
    switch_n = ((cur_n != cur) && (switch_count != 16'hFFFF)) ?
               switch_count + 16'd1 : switch_count;
  end

  // LED drive for the next cycle: dark while blanking, else the next source's pattern
  always_comb begin
    led_n = '0;
    if (state_n == ST_SHOW) begin
      case (cur_n)
        SRC_LOGIC:  led_n = logic_led;
        SRC_CYLON:  led_n = cylon_led;
        SRC_NOLINK: led_n = {16{fader_led}};
        SRC_OVR:    led_n = ovr_pat;
        SRC_ERR:    led_n = err_led;
        default:    led_n = '0;
      endcase
    end
  end

  // Override handshake: accept on rising edge, count displayed cycles, abort on error
  always_comb begin
    busy_n    = ovr_busy;
    ovr_cnt_n = ovr_cnt;
    ovr_pat_n = ovr_pat;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    if (ovr_busy) begin
      if (err_req) begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        abort_n = 1'b1;
      end else if (ovr_show_c) begin
        ovr_cnt_n = ovr_cnt - 24'd1;
        if (ovr_ending_c) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
    end else if (ovr_req && !ovr_req_q && !err_req) begin
      if (ovr_cycles == 24'd0) begin
        done_n  = 1'b1;
        abort_n = 1'b1;
      end else begin
        busy_n    = 1'b1;
        ovr_cnt_n = ovr_cycles;
        ovr_pat_n = ovr_pattern;
      end
    end
  end

  // Scheduler registers; dwell starts satisfied so the first request switches at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_SHOW;
      cur          <= SRC_LOGIC;
      dwell_cnt    <= DWELL_MAX;
      blank_cnt    <= '0;
      led_out      <= '0;
      switch_count <= '0;
    end else begin
      state        <= state_n;
      cur          <= cur_n;
      dwell_cnt    <= dwell_n;
      blank_cnt    <= blank_n;
      led_out      <= led_n;
      switch_count <= switch_n;
    end
  end

  // Override registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovr_req_q   <= 1'b0;
      ovr_busy    <= 1'b0;
      ovr_done    <= 1'b0;
      ovr_aborted <= 1'b0;
      ovr_cnt     <= '0;
      ovr_pat     <= '0;
    end else begin
      ovr_req_q   <= ovr_req;
      ovr_busy    <= busy_n;
      ovr_done    <= done_n;
      ovr_aborted <= abort_n;
      ovr_cnt     <= ovr_cnt_n;
      ovr_pat     <= ovr_pat_n;
    end
  end

endmodule

// File: tb/tb_led_source_sched.sv
// Directed bench for led_source_sched with DWELL_CYCLES=8, BLANK_CYCLES=2, plus a
// second instance without dwell/blank used to drive switch_count into saturation.
`timescale 1ns/1ps

module tb_led_source_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        err_req, nolink_req, fader_led, cylon_req, ovr_req, sat_cylon;
  logic [15:0] err_led, cylon_led, logic_led, ovr_pattern;
  logic [23:0] ovr_cycles;
  logic        ovr_busy, ovr_done, ovr_aborted;
  logic [15:0] led_out, switch_count;
  logic [2:0]  src_sel;
  logic        sat_busy, sat_done, sat_aborted;
  logic [15:0] sat_led, sat_count;
  logic [2:0]  sat_src;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  led_source_sched #(.DWELL_CYCLES(8), .BLANK_CYCLES(2), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .err_req(err_req), .err_led(err_led),
    .nolink_req(nolink_req), .fader_led(fader_led),
    .cylon_req(cylon_req), .cylon_led(cylon_led),
    .logic_led(logic_led),
    .ovr_req(ovr_req), .ovr_pattern(ovr_pattern), .ovr_cycles(ovr_cycles),
    .ovr_busy(ovr_busy), .ovr_done(ovr_done), .ovr_aborted(ovr_aborted),
    .led_out(led_out), .src_sel(src_sel), .switch_count(switch_count)
  );

  led_source_sched #(.DWELL_CYCLES(0), .BLANK_CYCLES(0), .CNT_WIDTH(4)) sat_dut (
    .clock(clock), .reset(reset),
    .err_req(err_req), .err_led(err_led),
    .nolink_req(nolink_req), .fader_led(fader_led),
    .cylon_req(sat_cylon), .cylon_led(cylon_led),
    .logic_led(logic_led),
    .ovr_req(ovr_req), .ovr_pattern(ovr_pattern), .ovr_cycles(ovr_cycles),
    .ovr_busy(sat_busy), .ovr_done(sat_done), .ovr_aborted(sat_aborted),
    .led_out(sat_led), .src_sel(sat_src), .switch_count(sat_count)
  );

  typedef struct {
    logic        err;
    logic        nolink;
    logic        cylon;
    logic [15:0] led;
    logic [2:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    err_req    = 1'b0;
    nolink_req = 1'b0;
    cylon_req  = 1'b0;
    ovr_req    = 1'b0;
    sat_cylon  = 1'b0;
    reset      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Global bound so a stuck run still ends
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int zrun, maxz, last_bs, min_gap, nsw, a5, zeros, dones, aborts;
    logic [2:0] prev_src;

    err_led     = 16'hDEAD;
    cylon_led   = 16'h3C3C;
    logic_led   = 16'h00F0;
    fader_led   = 1'b1;
    ovr_pattern = 16'hA5A5;
    ovr_cycles  = 24'd5;

    // Vectors: cylon with blank, ERR preemption, ERR held by dwell, blank back to cylon
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h00F0, 3'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd1, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd1, 16'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h3C3C, 3'd1, 16'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h3C3C, 3'd1, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h3C3C, 3'd1, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'hDEAD, 3'd4, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'hDEAD, 3'd4, 16'd2};
    for (int i = 8; i <= 14; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 16'hDEAD, 3'd4, 16'd2};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd1, 16'd3};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd1, 16'd3};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 16'h3C3C, 3'd1, 16'd3};

    // Reset values
    err_req = 1'b0; nolink_req = 1'b0; cylon_req = 1'b0; ovr_req = 1'b0; sat_cylon = 1'b0;
    reset = 1'b0;
    #12;
    chk("reset led_out", 32'(led_out), 32'h0);
    chk("reset src_sel", 32'(src_sel), 32'h0);
    chk("reset switch_count", 32'(switch_count), 32'h0);
    chk("reset ovr_busy", 32'(ovr_busy), 32'h0);
    chk("reset ovr_done", 32'(ovr_done), 32'h0);
    chk("reset ovr_aborted", 32'(ovr_aborted), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      err_req    = vecs[i].err;
      nolink_req = vecs[i].nolink;
      cylon_req  = vecs[i].cylon;
      @(negedge clock);
      chk($sformatf("vec%0d led_out", i), 32'(led_out), 32'(vecs[i].led));
      chk($sformatf("vec%0d src_sel", i), 32'(src_sel), 32'(vecs[i].src));
      chk($sformatf("vec%0d switch_count", i), 32'(switch_count), 32'(vecs[i].cnt));
    end

    // Asynchronous reset in the middle of a blank
    do_reset();
    cylon_req = 1'b1;
    @(negedge clock);
    chk("midblank pre src_sel", 32'(src_sel), 32'h1);
    chk("midblank pre led_out", 32'(led_out), 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("midblank reset src_sel", 32'(src_sel), 32'h0);
    chk("midblank reset switch_count", 32'(switch_count), 32'h0);

    // No-link chatter: blanks are 2 cycles and blank starts at least 10 cycles apart
    do_reset();
    zrun = 0; maxz = 0; last_bs = -1; min_gap = 1000; nsw = 0; prev_src = 3'd0;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) nolink_req = ~nolink_req;
      @(negedge clock);
      if (led_out == 16'h0000) begin
        zrun++;
        if (zrun == 1) begin
          if (last_bs >= 0 && (i - last_bs) < min_gap) min_gap = i - last_bs;
          last_bs = i;
        end
        if (zrun > maxz) maxz = zrun;
      end else begin
        zrun = 0;
      end
      if (src_sel != prev_src) nsw++;
      prev_src = src_sel;
    end
    chk("nolink longest dark run", 32'(maxz), 32'd2);
    chk("nolink blank spacing >= 10", 32'(min_gap >= 10), 32'd1);
    chk("nolink switches observed", 32'(nsw >= 3), 32'd1);
    chk("nolink switch_count vs observed", 32'(switch_count), 32'(nsw));

    // Normal override of 5 cycles; pattern input changes and a second edge while busy
    do_reset();
    repeat (2) @(negedge clock);
    ovr_pattern = 16'hA5A5; ovr_cycles = 24'd5; ovr_req = 1'b1;
    @(negedge clock);
    chk("ovr accept busy", 32'(ovr_busy), 32'h1);
    chk("ovr accept src_sel", 32'(src_sel), 32'h0);
    ovr_req = 1'b0; ovr_pattern = 16'h1234; ovr_cycles = 24'd3;
    a5 = 0; zeros = 0; dones = 0; aborts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 1) ovr_req = 1'b1;
      if (led_out == 16'hA5A5) a5++;
      if (led_out == 16'h0000) zeros++;
      if (ovr_done) dones++;
      if (ovr_aborted) aborts++;
    end
    chk("ovr displayed cycles", 32'(a5), 32'd5);
    chk("ovr dark cycles", 32'(zeros), 32'd4);
    chk("ovr done pulses", 32'(dones), 32'd1);
    chk("ovr aborted pulses", 32'(aborts), 32'd0);
    chk("ovr end led_out", 32'(led_out), 32'h00F0);
    chk("ovr end src_sel", 32'(src_sel), 32'h0);
    chk("ovr end busy", 32'(ovr_busy), 32'h0);
    chk("ovr end switch_count", 32'(switch_count), 32'd2);

    // Override of 20 cycles cut short by err_req on display cycle 3
    ovr_req = 1'b0;
    repeat (10) @(negedge clock);
    ovr_pattern = 16'hA5A5; ovr_cycles = 24'd20; ovr_req = 1'b1;
    @(negedge clock);
    ovr_req = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort display cycle 3 led", 32'(led_out), 32'hA5A5);
    err_req = 1'b1;
    @(negedge clock);
    chk("abort led_out", 32'(led_out), 32'hDEAD);
    chk("abort src_sel", 32'(src_sel), 32'h4);
    chk("abort busy", 32'(ovr_busy), 32'h0);
    chk("abort done", 32'(ovr_done), 32'h1);
    chk("abort aborted", 32'(ovr_aborted), 32'h1);
    @(negedge clock);
    chk("abort done one cycle", 32'(ovr_done), 32'h0);
    ovr_cycles = 24'd5; ovr_req = 1'b1;
    @(negedge clock);
    chk("edge during err busy", 32'(ovr_busy), 32'h0);
    chk("edge during err done", 32'(ovr_done), 32'h0);
    err_req = 1'b0; ovr_req = 1'b0;
    @(negedge clock);
    ovr_cycles = 24'd0; ovr_req = 1'b1;
    @(negedge clock);
    chk("zero-length done", 32'(ovr_done), 32'h1);
    chk("zero-length aborted", 32'(ovr_aborted), 32'h1);
    chk("zero-length busy", 32'(ovr_busy), 32'h0);
    chk("zero-length src_sel", 32'(src_sel), 32'h4);
    ovr_req = 1'b0;

    // Asynchronous reset while an override is on display
    do_reset();
    repeat (2) @(negedge clock);
    ovr_pattern = 16'hA5A5; ovr_cycles = 24'd10; ovr_req = 1'b1;
    @(negedge clock);
    ovr_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("midovr pre led_out", 32'(led_out), 32'hA5A5);
    #2 reset = 1'b0;
    #1;
    chk("midovr reset led_out", 32'(led_out), 32'h0);
    chk("midovr reset busy", 32'(ovr_busy), 32'h0);
    chk("midovr reset src_sel", 32'(src_sel), 32'h0);
    chk("midovr reset switch_count", 32'(switch_count), 32'h0);

    // Saturation of switch_count on the no-dwell, no-blank instance
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      sat_cylon = ~sat_cylon;
      @(negedge clock);
    end
    chk("sat count before saturation", 32'(sat_count), 32'd65534);
    chk("sat no-blank led_out", 32'(sat_led), 32'h00F0);
    sat_cylon = 1'b1;
    @(negedge clock);
    chk("sat no-blank switch led_out", 32'(sat_led), 32'h3C3C);
    chk("sat no-blank switch src_sel", 32'(sat_src), 32'h1);
    for (int i = 0; i < 4500; i++) begin
      sat_cylon = ~sat_cylon;
      @(negedge clock);
    end
    chk("sat count saturated", 32'(sat_count), 32'hFFFF);
    chk("sat idle busy", 32'(sat_busy), 32'h0);
    chk("sat idle done", 32'(sat_done | sat_aborted), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
